// File: rtl/io_port_pkg.sv
// io_port shared types: byte width and TX state encoding.
// Imported by io_port and io_port_fifo.
package io_port_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_FULL = 1'b1
    } tx_state_t;

endpackage

// File: rtl/io_port_fifo.sv
// io_port RX FIFO: DEPTH x DATA_W, natural-wrap pointers.
// Caller gates push with !full and pop with !empty.
module io_port_fifo
    import io_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       cnt;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push)
                wptr <= wptr + PTR_ONE;
            if (pop)
                rptr <= rptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/io_port.sv
// io_port: byte I/O bridge, RX FIFO in, single-entry TX out.
// Optional IO_PORT_LOOPBACK_EN adds a loopback input routing TX into RX.
module io_port
    import io_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IO_PORT_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [DATA_W-1:0] cpu_in,
    output logic              cpu_in_valid,
    input  logic              cpu_rd,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cpu_wr,
    output logic              cpu_out_busy,
    output logic              tx_overrun,
    input  logic [DATA_W-1:0] dev_rx_data,
    input  logic              dev_rx_valid,
    output logic              dev_rx_ready,
    output logic [DATA_W-1:0] dev_tx_data,
    output logic              dev_tx_valid,
    input  logic              dev_tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [DATA_W-1:0] tx_reg;
    logic              overrun_q;
    logic              tx_ready;
    logic              tx_fire;
    logic              busy;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_din;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_cnt;
    logic              rx_space;

    assign rx_space = !rst && (fifo_cnt != CNT_FULL);

    // Sink selection: device port, or the RX FIFO when looped back.
    always_comb begin
        tx_ready     = dev_tx_ready;
        fifo_din     = dev_rx_data;
        dev_rx_ready = rx_space;
`ifdef IO_PORT_LOOPBACK_EN
        if (loopback) begin
            tx_ready     = !fifo_full;
            fifo_din     = tx_reg;
            dev_rx_ready = 1'b0;
        end
`endif
    end

    always_comb begin
        fifo_push = dev_rx_valid && dev_rx_ready && !fifo_full;
`ifdef IO_PORT_LOOPBACK_EN
        if (loopback)
            fifo_push = tx_fire && !fifo_full;
`endif
    end

    assign fifo_pop = cpu_rd && !fifo_empty;

    io_port_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign cpu_in       = fifo_empty ? '0 : fifo_dout;
    assign cpu_in_valid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= TX_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE: if (cpu_wr)   state_d = TX_FULL;
            TX_FULL: if (tx_ready) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == TX_FULL);
        tx_fire      = busy && tx_ready;
        cpu_out_busy = busy;
        dev_tx_valid = busy;
`ifdef IO_PORT_LOOPBACK_EN
        if (loopback)
            dev_tx_valid = 1'b0;
`endif
    end

    // Any write while FULL, handshake edge included, is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_reg    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (!busy && cpu_wr)
                tx_reg <= cpu_out;
            if (busy && cpu_wr)
                overrun_q <= 1'b1;
        end
    end

    assign dev_tx_data = tx_reg;
    assign tx_overrun  = overrun_q;

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_io_port;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cpu_in;
    logic       cpu_in_valid;
    logic       cpu_rd = 1'b0;
    logic [7:0] cpu_out = 8'h00;
    logic       cpu_wr = 1'b0;
    logic       cpu_out_busy;
    logic       tx_overrun;
    logic [7:0] dev_rx_data = 8'h00;
    logic       dev_rx_valid = 1'b0;
    logic       dev_rx_ready;
    logic [7:0] dev_tx_data;
    logic       dev_tx_valid;
    logic       dev_tx_ready = 1'b0;
`ifdef IO_PORT_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    io_port #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef IO_PORT_LOOPBACK_EN
        .loopback     (loopback),
`endif
        .cpu_in       (cpu_in),
        .cpu_in_valid (cpu_in_valid),
        .cpu_rd       (cpu_rd),
        .cpu_out      (cpu_out),
        .cpu_wr       (cpu_wr),
        .cpu_out_busy (cpu_out_busy),
        .tx_overrun   (tx_overrun),
        .dev_rx_data  (dev_rx_data),
        .dev_rx_valid (dev_rx_valid),
        .dev_rx_ready (dev_rx_ready),
        .dev_tx_data  (dev_tx_data),
        .dev_tx_valid (dev_tx_valid),
        .dev_tx_ready (dev_tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [7:0] q[$];
    bit         m_busy;
    logic [7:0] m_txb;
    bit         m_ovr;
    bit         m_lb;
    logic [7:0] sent[$];

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] od;
        logic       rv;
        logic [7:0] rdat;
        logic       tr;
        logic [7:0] e_in;
        logic       e_valid;
        logic       e_rdy;
        logic       e_busy;
        logic [7:0] e_txd;
    } vec_t;

    vec_t tbl[10];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic check_all();
        logic [7:0] ein;
        ein = (q.size() != 0) ? q[0] : 8'h00;
        chk("cpu_in", cpu_in, ein);
        chk("cpu_in_valid", cpu_in_valid, q.size() != 0);
        chk("dev_rx_ready", dev_rx_ready, !m_lb && q.size() != DEPTH);
        chk("cpu_out_busy", cpu_out_busy, m_busy);
        chk("dev_tx_valid", dev_tx_valid, m_busy && !m_lb);
        chk("tx_overrun", tx_overrun, m_ovr);
        if (m_busy)
            chk("dev_tx_data", dev_tx_data, m_txb);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_cpu_in"}, cpu_in, 0);
        chk({tag, "_in_valid"}, cpu_in_valid, 0);
        chk({tag, "_rx_ready"}, dev_rx_ready, 0);
        chk({tag, "_busy"}, cpu_out_busy, 0);
        chk({tag, "_tx_valid"}, dev_tx_valid, 0);
        chk({tag, "_tx_data"}, dev_tx_data, 0);
        chk({tag, "_overrun"}, tx_overrun, 0);
    endtask

    task automatic model_clear();
        q.delete();
        m_busy = 0;
        m_txb = 8'h00;
        m_ovr = 0;
        sent.delete();
    endtask

    task automatic idle_inputs();
        cpu_rd = 0;
        cpu_wr = 0;
        cpu_out = 8'h00;
        dev_rx_valid = 0;
        dev_rx_data = 8'h00;
        dev_tx_ready = 0;
    endtask

    // Drive at negedge, model the edge, check at the next negedge.
    task automatic step(input logic rd, input logic wr, input logic [7:0] od,
                        input logic rv, input logic [7:0] rdat, input logic tr);
        int sz;
        bit nf, txr, push, pop, fire;
        logic [7:0] pd;
        cpu_rd = rd;
        cpu_wr = wr;
        cpu_out = od;
        dev_rx_valid = rv;
        dev_rx_data = rdat;
        dev_tx_ready = tr;
        sz = q.size();
        nf = (sz != DEPTH);
        txr = m_lb ? nf : tr;
        push = m_lb ? (m_busy && nf) : (rv && nf);
        pd = m_lb ? m_txb : rdat;
        pop = rd && (sz > 0);
        fire = m_busy && txr;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(pd);
        if (fire && !m_lb) sent.push_back(m_txb);
        if (m_busy) begin
            if (wr) m_ovr = 1;
            if (txr) m_busy = 0;
        end else if (wr) begin
            m_busy = 1;
            m_txb = od;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #2 rst = 1;
        #1 check_zero("rst");
        model_clear();
        #1 rst = 0;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        m_lb = 0;
        model_clear();
        #1 check_zero("por");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_all();

        tbl[0] = '{0,0,8'h00,1,8'hA1,0, 8'hA1,1,1,0,8'h00};
        tbl[1] = '{0,0,8'h00,1,8'hB2,0, 8'hA1,1,1,0,8'h00};
        tbl[2] = '{0,0,8'h00,1,8'hC3,0, 8'hA1,1,1,0,8'h00};
        tbl[3] = '{1,0,8'h00,0,8'h00,0, 8'hB2,1,1,0,8'h00};
        tbl[4] = '{1,0,8'h00,0,8'h00,0, 8'hC3,1,1,0,8'h00};
        tbl[5] = '{1,0,8'h00,0,8'h00,0, 8'h00,0,1,0,8'h00};
        tbl[6] = '{0,1,8'h5A,0,8'h00,0, 8'h00,0,1,1,8'h5A};
        tbl[7] = '{0,0,8'h00,0,8'h00,0, 8'h00,0,1,1,8'h5A};
        tbl[8] = '{0,0,8'h00,0,8'h00,0, 8'h00,0,1,1,8'h5A};
        tbl[9] = '{0,0,8'h00,0,8'h00,1, 8'h00,0,1,0,8'h00};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].od,
                 tbl[i].rv, tbl[i].rdat, tbl[i].tr);
            chk($sformatf("vec%0d_in", i), cpu_in, tbl[i].e_in);
            chk($sformatf("vec%0d_valid", i), cpu_in_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_rdy", i), dev_rx_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_busy", i), cpu_out_busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_txv", i), dev_tx_valid, tbl[i].e_busy);
            if (tbl[i].e_busy)
                chk($sformatf("vec%0d_txd", i), dev_tx_data, tbl[i].e_txd);
        end

        // RX full and hold-off
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1, 8'(8'h10 + i), 0);
            if (i == 3) chk("rx_full_rdy", dev_rx_ready, 0);
        end
        chk("rx_full_head", cpu_in, 8'h10);
        step(1, 0, 8'h00, 1, 8'h99, 0);
        chk("rx_full_pop_head", cpu_in, 8'h11);
        step(0, 0, 8'h00, 1, 8'h98, 0);
        chk("rx_refill_rdy", dev_rx_ready, 0);
        step(1, 0, 8'h00, 1, 8'h97, 0);
        step(1, 0, 8'h00, 1, 8'h96, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 8'h00, 0, 8'h00, 0);
        chk("rx_drained", cpu_in_valid, 0);

        // TX overrun
        do_reset();
        step(0, 1, 8'h11, 0, 8'h00, 0);
        step(0, 1, 8'h22, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1);
        step(0, 1, 8'h33, 0, 8'h00, 0);
        step(0, 1, 8'h44, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0, 8'h00, 0);
        chk("ovr_flag", tx_overrun, 1);
        chk("ovr_sent_n", sent.size(), 2);
        if (sent.size() == 2) begin
            chk("ovr_sent0", sent[0], 8'h11);
            chk("ovr_sent1", sent[1], 8'h33);
        end

        // Reset mid-operation
        do_reset();
        step(0, 0, 8'h00, 1, 8'hE1, 0);
        step(0, 0, 8'h00, 1, 8'hE2, 0);
        step(0, 1, 8'h5A, 0, 8'h00, 0);
        step(0, 1, 8'h6B, 0, 8'h00, 0);
        do_reset();
        chk("post_rst_empty", cpu_in_valid, 0);
        chk("post_rst_rdy", dev_rx_ready, 1);

`ifdef IO_PORT_LOOPBACK_EN
        loopback = 1;
        m_lb = 1;
        step(0, 1, 8'h7E, 0, 8'h00, 0);
        chk("lb_txv0", dev_tx_valid, 0);
        step(0, 0, 8'h00, 1, 8'h55, 1);
        chk("lb_cpu_in", cpu_in, 8'h7E);
        chk("lb_txv1", dev_tx_valid, 0);
        step(1, 0, 8'h00, 0, 8'h00, 0);
        loopback = 0;
        m_lb = 0;
        @(negedge clk);
        check_all();
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
`ifdef IO_PORT_LOOPBACK_EN
            if ($urandom_range(0, 49) == 0) begin
                loopback = ~loopback;
                m_lb = loopback;
            end
`endif
            step(1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0),
                 8'($urandom),
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
